// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory request/response bus between fetch (master) and memory (slave).
interface instruction_fetch_unit_if;

    logic        Imem_Req_Valid;
    logic        Imem_Req_Ready;
    logic [31:0] Imem_Req_Addr;
    logic        Imem_Rsp_Valid;
    logic [31:0] Imem_Rsp_Data;

    modport master (
        output Imem_Req_Valid,
        output Imem_Req_Addr,
        input  Imem_Req_Ready,
        input  Imem_Rsp_Valid,
        input  Imem_Rsp_Data
    );

    modport slave (
        input  Imem_Req_Valid,
        input  Imem_Req_Addr,
        output Imem_Req_Ready,
        output Imem_Rsp_Valid,
        output Imem_Rsp_Data
    );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: one outstanding imem request, a single-entry buffer towards decode,
// and flush handling that discards responses belonging to a stale PC.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
(
    input  logic                      Clk_Core,
    input  logic                      Rst_Core_N,
    input  logic [31:0]               Program_Count,
    input  logic                      Flush,
    instruction_fetch_unit_if.master  imem,
    input  logic                      Dec_Ready,
    output logic                      Fetch_Halt,
    output logic                      Instr_Valid,
    output logic [31:0]               Instr,
    output logic [31:0]               Instr_PC,
    output logic                      Instr_Fault
);

    fetch_state_e state_q, state_d;
    logic         discard_q, discard_d;
    logic [31:0]  pc_q, pc_d;
    logic         instr_valid_d;
    logic [31:0]  instr_d;
    logic [31:0]  instr_pc_d;
    logic         instr_fault_d;
    logic         misaligned;

    assign misaligned = (Program_Count[1:0] != 2'b00);

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            state_q     <= S_REQ;
            discard_q   <= 1'b0;
            pc_q        <= '0;
            Instr_Valid <= 1'b0;
            Instr       <= NOP_INSTR;
            Instr_PC    <= '0;
            Instr_Fault <= 1'b0;
        end else begin
            state_q     <= state_d;
            discard_q   <= discard_d;
            pc_q        <= pc_d;
            Instr_Valid <= instr_valid_d;
            Instr       <= instr_d;
            Instr_PC    <= instr_pc_d;
            Instr_Fault <= instr_fault_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        discard_d           = discard_q;
        pc_d                = pc_q;
        instr_valid_d       = Instr_Valid;
        instr_d             = Instr;
        instr_pc_d          = Instr_PC;
        instr_fault_d       = Instr_Fault;
        imem.Imem_Req_Valid = 1'b0;
        imem.Imem_Req_Addr  = Program_Count;
        Fetch_Halt          = 1'b1;

        // PC advances only on an accepted instruction or a redirect
        if (Rst_Core_N && (Flush || (state_q == S_HOLD && Dec_Ready))) begin
            Fetch_Halt = 1'b0;
        end

        unique case (state_q)
            S_REQ: begin
                imem.Imem_Req_Valid = Rst_Core_N && !misaligned;
                if (!misaligned) begin
                    if (imem.Imem_Req_Ready) begin
                        pc_d      = Program_Count;
                        discard_d = Flush;
                        state_d   = S_WAIT;
                    end
                end else if (!Flush) begin
                    instr_valid_d = 1'b1;
                    instr_d       = NOP_INSTR;
                    instr_pc_d    = Program_Count;
                    instr_fault_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_WAIT: begin
                if (imem.Imem_Rsp_Valid) begin
                    discard_d = 1'b0;
                    if (Flush || discard_q) begin
                        state_d = S_REQ;
                    end else begin
                        instr_valid_d = 1'b1;
                        instr_d       = imem.Imem_Rsp_Data;
                        instr_pc_d    = pc_q;
                        instr_fault_d = 1'b0;
                        state_d       = S_HOLD;
                    end
                end else if (Flush) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (Flush || Dec_Ready) begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    instr_fault_d = 1'b0;
                    state_d       = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have Clk_Core  input  1  core clock, rising edge active.
REQ-002 SHALL have Rst_Core_N  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have Program_Count  input  32  current PC from the program counter stage.
REQ-004 SHALL have Flush  input  1  redirect pulse, same cycle as PC_Sel=1 at the program counter.
REQ-005 SHALL have Imem_Req_Ready  input  1  instruction memory accepts a request.
REQ-006 SHALL have Imem_Rsp_Valid  input  1  instruction memory response valid.
REQ-007 SHALL have Imem_Rsp_Data  input  32  response instruction word.
REQ-008 SHALL have Dec_Ready  input  1  decode accepts the held instruction.
REQ-009 SHALL have Imem_Req_Valid  output  1  request valid.
REQ-010 SHALL have Imem_Req_Addr  output  32  request word address.
REQ-011 SHALL have Fetch_Halt  output  1  drives the program counter Halt input.
REQ-012 SHALL have Instr_Valid  output  1  Instr/Instr_PC valid to decode.
REQ-013 SHALL have Instr  output  32  fetched instruction; 0x00000013 (NOP) when Instr_Valid=0.
REQ-014 SHALL have Instr_PC  output  32  PC of Instr.
REQ-015 SHALL have Instr_Fault  output  1  misaligned-fetch flag, qualified by Instr_Valid.

Function
REQ-016 SHALL use FSM states S_REQ, S_WAIT, S_HOLD; one outstanding request maximum.
REQ-017 S_REQ: SHALL drive Imem_Req_Valid=1, Imem_Req_Addr=Program_Count; on Imem_Req_Ready latch Program_Count into pc_q and go to S_WAIT.
REQ-018 S_REQ with Program_Count[1:0]!=0: SHALL NOT request memory; SHALL go to S_HOLD with Instr_Fault=1, Instr=NOP, Instr_PC=Program_Count.
REQ-019 S_WAIT: on Imem_Rsp_Valid with discard=0, SHALL register Imem_Rsp_Data and pc_q into the output buffer and go to S_HOLD; Instr_Valid rises the next cycle.
REQ-020 S_HOLD: SHALL hold Instr_Valid=1 with stable Instr/Instr_PC/Instr_Fault until Dec_Ready=1, then go to S_REQ.
REQ-021 Fetch_Halt SHALL be 0 exactly when (S_HOLD and Dec_Ready) or Flush; otherwise 1. The PC therefore advances once per accepted instruction.
REQ-022 Flush in S_HOLD: SHALL drop the buffer, deassert Instr_Valid the next cycle, and go to S_REQ.
REQ-023 Flush in S_REQ with Imem_Req_Ready=1: SHALL set discard and go to S_WAIT; without Ready, SHALL stay in S_REQ (new PC presented next cycle).
REQ-024 Flush in S_WAIT without Imem_Rsp_Valid: SHALL set discard and stay in S_WAIT.
REQ-025 Flush in S_WAIT together with Imem_Rsp_Valid: SHALL drop the response and go to S_REQ.
REQ-026 S_WAIT with Imem_Rsp_Valid and discard=1: SHALL drop the response, clear discard, and go to S_REQ.
REQ-027 Imem_Rsp_Valid outside S_WAIT SHALL be ignored.
REQ-028 Minimum latency SHALL be 3 cycles per instruction (REQ, WAIT with same-cycle response, HOLD).

Reset
REQ-029 Reset assertion SHALL force S_REQ, discard=0, Imem_Req_Valid=0 and Instr_Valid=0 during reset, Fetch_Halt=1, Instr=NOP, Instr_PC=0, Instr_Fault=0, pc_q=0, regardless of state.
REQ-030 First request SHALL issue in the first cycle after Rst_Core_N deasserts, with address 0x00000000.

Structure
REQ-031 Shared package SHALL hold the state enum (2-bit) and the NOP constant 32'h00000013.
REQ-032 Block SHALL be a single module with no sub-modules; all outputs registered except Imem_Req_Valid, Imem_Req_Addr and Fetch_Halt.

Verification
REQ-033 Reset release, Ready=1, response 1 cycle later with 0x00500093, Dec_Ready=1 -> Instr_Valid with Instr=0x00500093, Instr_PC=0, Fetch_Halt low one cycle, next Imem_Req_Addr=0x4.
REQ-034 Dec_Ready=0 for 5 cycles in S_HOLD -> Instr stable, Fetch_Halt=1, no new request.
REQ-035 Flush while in S_WAIT, then response 0xDEADBEEF -> response dropped, Instr_Valid stays 0, request reissued at redirected PC.
REQ-036 Flush in the same cycle as Imem_Rsp_Valid -> no Instr_Valid, S_REQ the next cycle.
REQ-037 Program_Count=0x00000102 -> no Imem_Req_Valid, Instr_Valid=1 with Instr_Fault=1, Instr_PC=0x102.
REQ-038 Rst_Core_N asserted in S_HOLD -> Instr_Valid=0 immediately, request at 0x0 after release.
